// File: rtl/fpu_result_fifo_if.sv
// Handshake bundle between the FPU completion strobe, the result FIFO and its consumer.
// FPU_RES_STATS_EN adds the per-status counters and their clear input.
interface fpu_result_fifo_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     res_valid_in;
    logic [31:0]              data_in;
    logic [3:0]               status_in;
    logic                     out_ready;
    logic                     out_valid;
    logic [31:0]              data_out;
    logic [3:0]               status_out;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     lost_out;
    logic                     err_status;
    logic [CNT_W-1:0]         drop_cnt;
`ifdef FPU_RES_STATS_EN
    logic                     stats_clr;
    logic [CNT_W-1:0]         cnt_exact;
    logic [CNT_W-1:0]         cnt_inexact;
    logic [CNT_W-1:0]         cnt_overflow;
    logic [CNT_W-1:0]         cnt_underflow;

    modport master (
        output res_valid_in, data_in, status_in, out_ready, stats_clr,
        input  out_valid, data_out, status_out, level, full, lost_out, err_status, drop_cnt,
               cnt_exact, cnt_inexact, cnt_overflow, cnt_underflow
    );
    modport slave (
        input  res_valid_in, data_in, status_in, out_ready, stats_clr,
        output out_valid, data_out, status_out, level, full, lost_out, err_status, drop_cnt,
               cnt_exact, cnt_inexact, cnt_overflow, cnt_underflow
    );
`else
    modport master (
        output res_valid_in, data_in, status_in, out_ready,
        input  out_valid, data_out, status_out, level, full, lost_out, err_status, drop_cnt
    );
    modport slave (
        input  res_valid_in, data_in, status_in, out_ready,
        output out_valid, data_out, status_out, level, full, lost_out, err_status, drop_cnt
    );
`endif
endinterface

// File: rtl/fpu_result_fifo.sv
// Show-ahead result FIFO behind the FPU: captures {data,status} on each completion strobe.
// Optional per-status statistics counters are enabled by defining FPU_RES_STATS_EN.
module fpu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic              clock100KHz,
    input logic              reset,
    fpu_result_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DEPTH-1:0][35:0] mem_q, mem_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   lost_q, lost_d, err_q, err_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic                   push, pop, accept, is_full, one_hot;

    // A zero status is the FPU's idle value, so it never counts as a result.
    assign push    = bus.res_valid_in && (bus.status_in != 4'b0000);
    assign is_full = (level_q == LW'(DEPTH));
    assign pop     = (level_q != '0) && bus.out_ready;
    assign accept  = push && (!is_full || pop);
    assign one_hot = (bus.status_in & (bus.status_in - 4'd1)) == 4'b0000;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        lost_d   = lost_q;
        err_d    = err_q;
        drop_d   = drop_q;
        if (accept) begin
            mem_d[wr_ptr_q] = {bus.status_in, bus.data_in};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            if (!one_hot) err_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        level_d = level_q + LW'(accept) - LW'(pop);
        if (push && !accept) begin
            lost_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lost_q   <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            lost_q   <= lost_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.out_valid  = (level_q != '0);
    assign bus.data_out   = bus.out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign bus.status_out = bus.out_valid ? mem_q[rd_ptr_q][35:32] : 4'h0;
    assign bus.level      = level_q;
    assign bus.full       = is_full;
    assign bus.lost_out   = lost_q;
    assign bus.err_status = err_q;
    assign bus.drop_cnt   = drop_q;

`ifdef FPU_RES_STATS_EN
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-edge increment; non-one-hot statuses match no counter.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.stats_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.status_in == (4'b0001 << i) && cnt_q[i] != '1)
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.cnt_exact     = cnt_q[0];
    assign bus.cnt_inexact   = cnt_q[1];
    assign bus.cnt_overflow  = cnt_q[2];
    assign bus.cnt_underflow = cnt_q[3];
`endif
endmodule

// File: tb/tb_fpu_result_fifo.sv
// Directed bench for fpu_result_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fpu_result_fifo;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic clock100KHz = 1'b0;
    logic reset       = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    fpu_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    fpu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 clock100KHz = ~clock100KHz;

    // Reference model: a plain queue plus sticky flags and counters.
    ent_t            mq[$];
    logic            m_lost, m_err;
    int              m_drop;
    int              m_cnt[4];
    localparam int   SAT = (1 << CNT_W) - 1;

    always @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_lost = 0; m_err = 0; m_drop = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            bit do_pop, do_push, clr;
            int sz;
            sz      = mq.size();
            do_pop  = (sz > 0) && bus.out_ready;
            do_push = bus.res_valid_in && (bus.status_in != 0);
            clr     = 0;
`ifdef FPU_RES_STATS_EN
            clr = bus.stats_clr;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (sz < DEPTH || do_pop) begin
                    mq.push_back('{d: bus.data_in, s: bus.status_in});
                    if ($countones(bus.status_in) != 1) m_err = 1;
                    else if (!clr) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.status_in[i] && m_cnt[i] < SAT) m_cnt[i]++;
                    end
                end else begin
                    m_lost = 1;
                    if (m_drop < SAT) m_drop++;
                end
            end
            if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock100KHz) begin
        int sz;
        sz = mq.size();
        chk("m.out_valid",  64'(bus.out_valid),  64'(sz != 0));
        chk("m.data_out",   64'(bus.data_out),   sz != 0 ? 64'(mq[0].d) : 64'h0);
        chk("m.status_out", 64'(bus.status_out), sz != 0 ? 64'(mq[0].s) : 64'h0);
        chk("m.level",      64'(bus.level),      64'(sz));
        chk("m.full",       64'(bus.full),       64'(sz == DEPTH));
        chk("m.lost_out",   64'(bus.lost_out),   64'(m_lost));
        chk("m.err_status", 64'(bus.err_status), 64'(m_err));
        chk("m.drop_cnt",   64'(bus.drop_cnt),   64'(m_drop));
`ifdef FPU_RES_STATS_EN
        chk("m.cnt_exact",     64'(bus.cnt_exact),     64'(m_cnt[0]));
        chk("m.cnt_inexact",   64'(bus.cnt_inexact),   64'(m_cnt[1]));
        chk("m.cnt_overflow",  64'(bus.cnt_overflow),  64'(m_cnt[2]));
        chk("m.cnt_underflow", 64'(bus.cnt_underflow), 64'(m_cnt[3]));
`endif
    end

    // Inputs are applied 2 time units after a rising edge and held for exactly one edge.
    task automatic step(input logic rv, input logic [31:0] d, input logic [3:0] s, input logic rdy);
        bus.res_valid_in = rv;
        bus.data_in      = d;
        bus.status_in    = s;
        bus.out_ready    = rdy;
        @(posedge clock100KHz);
        #2;
    endtask

    localparam logic [31:0] A1 = 32'h3F80_0001;
    localparam logic [31:0] A2 = 32'h4000_0002;
    localparam logic [31:0] A3 = 32'h8123_4568;
    localparam logic [31:0] WB = 32'h1000_0000;

    initial begin
        bus.res_valid_in = 0;
        bus.data_in      = 0;
        bus.status_in    = 0;
        bus.out_ready    = 0;
`ifdef FPU_RES_STATS_EN
        bus.stats_clr    = 0;
`endif
        @(posedge clock100KHz);
        @(posedge clock100KHz);
        #2 reset = 0;
        chk("rst.level", 64'(bus.level), 0);
        chk("rst.out_valid", 64'(bus.out_valid), 0);

        // Ordered capture with a stalled consumer, then drain.
        step(1, A1, 4'b0001, 0);
        step(1, A2, 4'b0010, 0);
        step(1, A3, 4'b1000, 0);
        chk("t1.level", 64'(bus.level), 3);
        chk("t1.head", 64'(bus.data_out), 64'(A1));
        chk("t1.status", 64'(bus.status_out), 1);
        chk("t1.pop0", 64'(bus.data_out), 64'(A1)); step(0, 0, 0, 1);
        chk("t1.pop1", 64'(bus.data_out), 64'(A2)); step(0, 0, 0, 1);
        chk("t1.pop2", 64'(bus.data_out), 64'(A3));
        chk("t1.pop2s", 64'(bus.status_out), 8);    step(0, 0, 0, 1);
        chk("t1.empty", 64'(bus.level), 0);
        chk("t1.data0", 64'(bus.data_out), 0);

        // Overflow: ninth push is dropped.
        for (int i = 0; i < 9; i++) begin
            step(1, WB + i, 4'b0001, 0);
            if (i == 7) begin
                chk("t2.full8", 64'(bus.full), 1);
                chk("t2.nolost", 64'(bus.lost_out), 0);
            end
        end
        chk("t2.level", 64'(bus.level), 8);
        chk("t2.lost", 64'(bus.lost_out), 1);
        chk("t2.drop", 64'(bus.drop_cnt), 1);

        // Full with simultaneous push and pop: no drop, new word lands at tail.
        step(1, 32'hABCD_0009, 4'b0010, 1);
        chk("t3.level", 64'(bus.level), 8);
        chk("t3.drop", 64'(bus.drop_cnt), 1);
        chk("t3.head", 64'(bus.data_out), 64'(WB + 1));
        for (int i = 1; i < 8; i++) begin
            chk("t3.drain", 64'(bus.data_out), 64'(WB + i));
            step(0, 0, 0, 1);
        end
        chk("t3.tail", 64'(bus.data_out), 64'h0000_0000_ABCD_0009);
        chk("t3.tails", 64'(bus.status_out), 2);
        step(0, 0, 0, 1);
        chk("t3.empty", 64'(bus.level), 0);

        // Idle status ignored; non-one-hot stored and flagged; empty push+pop is push only.
        step(1, 32'hDEAD_0000, 4'b0000, 0);
        chk("t4.idle.level", 64'(bus.level), 0);
        chk("t4.idle.err", 64'(bus.err_status), 0);
        chk("t4.idle.drop", 64'(bus.drop_cnt), 1);
        step(1, 32'h0000_0033, 4'b0011, 0);
        chk("t4.bad.level", 64'(bus.level), 1);
        chk("t4.bad.err", 64'(bus.err_status), 1);
        chk("t4.bad.status", 64'(bus.status_out), 3);
        step(1, 32'h0000_0077, 4'b0001, 1);
        chk("t4.pp.level", 64'(bus.level), 1);
        chk("t4.pp.head", 64'(bus.data_out), 64'h77);
        step(0, 0, 0, 1);
        step(1, 32'h0000_0088, 4'b0001, 1);
        chk("t4.empty_pp.level", 64'(bus.level), 1);
        chk("t4.empty_pp.head", 64'(bus.data_out), 64'h88);
        step(0, 0, 0, 1);

        // Asynchronous reset mid-cycle while holding five entries.
        for (int i = 0; i < 5; i++) step(1, 32'h500 + i, 4'b0010, 0);
        chk("t5.level5", 64'(bus.level), 5);
        bus.out_ready = 1;
        #2 reset = 1;
        #1;
        chk("t5.level", 64'(bus.level), 0);
        chk("t5.valid", 64'(bus.out_valid), 0);
        chk("t5.data", 64'(bus.data_out), 0);
        chk("t5.status", 64'(bus.status_out), 0);
        chk("t5.lost", 64'(bus.lost_out), 0);
        chk("t5.err", 64'(bus.err_status), 0);
        chk("t5.drop", 64'(bus.drop_cnt), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        reset = 0;
        step(1, 32'h0000_0600, 4'b0001, 0);
        chk("t5.post.level", 64'(bus.level), 1);
        chk("t5.post.head", 64'(bus.data_out), 64'h600);

`ifdef FPU_RES_STATS_EN
        reset = 1;
        #1 reset = 0;
        step(1, 32'h1, 4'b0001, 0);
        step(1, 32'h2, 4'b0001, 0);
        step(1, 32'h3, 4'b0100, 0);
        chk("t6.exact", 64'(bus.cnt_exact), 2);
        chk("t6.overflow", 64'(bus.cnt_overflow), 1);
        chk("t6.inexact", 64'(bus.cnt_inexact), 0);
        bus.stats_clr = 1;
        step(1, 32'h4, 4'b0001, 0);
        bus.stats_clr = 0;
        chk("t6.clr.exact", 64'(bus.cnt_exact), 0);
        chk("t6.clr.overflow", 64'(bus.cnt_overflow), 0);
        chk("t6.clr.level", 64'(bus.level), 4);
`endif

        step(0, 0, 0, 0);
        @(negedge clock100KHz);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
